filter_window_sequencer: RTL
============================

# filter_window_sequencer

Sequencer that drives the 3×3 12-bit RGB444 convolution filters, such as the high-boost and blur effects. It walks a frame stored in a source pixel memory in raster order and fetches each pixel's 3×3 neighbourhood. It presents the neighbourhood as one packed 108-bit window to the filter, then writes the filter's 12-bit result to a destination memory at the same address. It sits between the frame buffers and any effect module that has the shared `color_data` / `filter_rgb_out` interface.

## Interface
Parameters:
- `IMG_W`, default 160: frame width in pixels (≥2).
- `IMG_H`, default 120: frame height in pixels (≥2).
- `ADDR_W`, default 15: memory address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.
- `FILTER_LAT`, default 4: rising edges from a `win_data` change to the matching valid `filt_in`; range 1..4.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last destination write.
- `src_addr`, out, ADDR_W: source read address; read data returns one cycle later.
- `src_rdata`, in, 12: source read data.
- `win_data`, out, 108: packed window, to the filter's `color_data`.
- `filt_in`, in, 12: filter result, from the filter's `filter_rgb_out`.
- `dst_addr`, out, ADDR_W: destination write address.
- `dst_wdata`, out, 12: destination write data; equals `filt_in` while `dst_we` is high.
- `dst_we`, out, 1: destination write strobe.

## Operation
- Window packing, MSB first, 12 bits each: centre [107:96], left [95:84], right [83:72], up [71:60], down [59:48], upleft [47:36], upright [35:24], downleft [23:12], downright [11:0].
- Pixel address is y·IMG_W + x. Scan order: x advances fastest, then y.
- Border handling: neighbour coordinates are clamped to [0, IMG_W−1] × [0, IMG_H−1], so edge pixels are replicated.
- FSM states:
  - IDLE: leaves on `start` to FETCH with x = y = 0.
  - FETCH: issues one `src_addr` per cycle, in the packing order above; goes to LOAD after the last address.
  - LOAD: captures the final read word, updates `win_data` on the edge that ends LOAD, and latches `dst_addr`. The next state is FETCH for the next pixel, or DRAIN after pixel (IMG_W−1, IMG_H−1).
  - DRAIN: waits for the final write, then returns to IDLE and pulses `done`.
- Each read word is written into its window slot on the edge after its address cycle.
- `win_data` holds its value between LOAD edges.
- Write scheduling: a FILTER_LAT-deep valid shift register is loaded at each LOAD edge. `dst_we` is high for exactly one cycle, the cycle after the FILTER_LAT-th edge after that LOAD edge.
- Only one window is ever in flight, because the minimum issue period (4 cycles, see Timing) is at least FILTER_LAT.

## Timing
- Reset values: `busy` = 0, `done` = 0, `dst_we` = 0, `src_addr` = 0, `dst_addr` = 0, `dst_wdata` = 0, `win_data` = 0. State returns to IDLE.
- Per-pixel period is 10 cycles without `SEQ_WINDOW_REUSE_EN` (9 FETCH + 1 LOAD).
- With reuse: x = 0 costs 10 cycles; x > 0 costs 4 cycles (3 FETCH + 1 LOAD).
- A full frame takes IMG_W·IMG_H·10 + FILTER_LAT + 1 cycles from `start` to `done`, without reuse.
- `start` together with `reset`: reset wins.
- `start` while `busy`: no effect.
- Reset in mid-frame: all activity aborts, no further writes occur, and the block needs a new `start`.

## Configuration
- `SEQ_WINDOW_REUSE_EN` defined: when x > 0, the left column ← old centre column and the centre column ← old right column. Only upright, right and downright are fetched, in that order.
- Not defined: every pixel fetches all 9 words. This yields the same written data with a longer period.

## Structure
- Shared package `filter_pkg`:
  - Window slot index constants (`SLOT_CENTRE` … `SLOT_DOWNRIGHT`).
  - Slot width 12 and window width 108.
  - The state enum `seq_state_t`.
- One sub-module, `window_addr_gen`: maps (x, y, slot) to a clamped linear address. It is purely combinational.

## Test plan
- 4×3 frame, every pixel 0x888, trivial pass-through filter model with FILTER_LAT = 4 → all 12 destination words written with 0x888; `done` 4+1 cycles after the last LOAD.
- Pixel (0,0) of a ramp frame (value = address) → window centre/left/up/upleft all 0x000; right = 0x001, down = 0x004, downright = 0x005 for IMG_W = 4.
- Pixel (3,2) corner of the same frame → right/down/downright slots replicate edge values; `dst_addr` = 11.
- With `SEQ_WINDOW_REUSE_EN`: 10 cycles for x = 0, then 4 cycles per pixel; destination contents are bit-identical to the non-reuse run.
- `start` pulsed again mid-frame → ignored; exactly IMG_W·IMG_H writes occur and there is one `done`.
- Reset asserted during FETCH of pixel 5 → all outputs reach their reset values; no `dst_we` afterwards; a new `start` completes the full frame.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 RGB444 window sequencer: slot indices, widths and FSM states.
package filter_pkg;

    localparam int SLOT_W     = 12;
    localparam int NUM_SLOTS  = 9;
    localparam int WIN_W      = SLOT_W * NUM_SLOTS;

    localparam logic [3:0] SLOT_CENTRE    = 4'd0;
    localparam logic [3:0] SLOT_LEFT      = 4'd1;
    localparam logic [3:0] SLOT_RIGHT     = 4'd2;
    localparam logic [3:0] SLOT_UP        = 4'd3;
    localparam logic [3:0] SLOT_DOWN      = 4'd4;
    localparam logic [3:0] SLOT_UPLEFT    = 4'd5;
    localparam logic [3:0] SLOT_UPRIGHT   = 4'd6;
    localparam logic [3:0] SLOT_DOWNLEFT  = 4'd7;
    localparam logic [3:0] SLOT_DOWNRIGHT = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_DRAIN
    } seq_state_t;

    // Slot whose previous value lands in slot s when the window slides one pixel right.
    function automatic logic [3:0] shift_src(input logic [3:0] s);
        case (s)
            SLOT_LEFT:     return SLOT_CENTRE;
            SLOT_UPLEFT:   return SLOT_UP;
            SLOT_DOWNLEFT: return SLOT_DOWN;
            SLOT_CENTRE:   return SLOT_RIGHT;
            SLOT_UP:       return SLOT_UPRIGHT;
            SLOT_DOWN:     return SLOT_DOWNRIGHT;
            default:       return s;
        endcase
    endfunction

    // Fetch order of the new right column when the window slides.
    function automatic logic [3:0] reuse_slot(input logic [3:0] idx);
        case (idx)
            4'd0:    return SLOT_UPRIGHT;
            4'd1:    return SLOT_RIGHT;
            default: return SLOT_DOWNRIGHT;
        endcase
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational map from (x, y, window slot) to a linear pixel address with edge clamping.
module window_addr_gen
    import filter_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15,
    parameter int X_W    = $clog2(IMG_W),
    parameter int Y_W    = $clog2(IMG_H)
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [3:0]        slot,
    output logic [ADDR_W-1:0] addr
);

    logic go_left, go_right, go_up, go_down;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;

    always_comb begin
        go_left  = (slot == SLOT_LEFT)  || (slot == SLOT_UPLEFT)   || (slot == SLOT_DOWNLEFT);
        go_right = (slot == SLOT_RIGHT) || (slot == SLOT_UPRIGHT)  || (slot == SLOT_DOWNRIGHT);
        go_up    = (slot == SLOT_UP)    || (slot == SLOT_UPLEFT)   || (slot == SLOT_UPRIGHT);
        go_down  = (slot == SLOT_DOWN)  || (slot == SLOT_DOWNLEFT) || (slot == SLOT_DOWNRIGHT);

        // A neighbour off the frame edge falls back to the edge pixel itself.
        nx = x;
        if (go_left && (x != '0))
            nx = x - 1'b1;
        if (go_right && (x != X_W'(IMG_W - 1)))
            nx = x + 1'b1;

        ny = y;
        if (go_up && (y != '0))
            ny = y - 1'b1;
        if (go_down && (y != Y_W'(IMG_H - 1)))
            ny = y + 1'b1;

        addr = ADDR_W'(ny) * ADDR_W'(IMG_W) + ADDR_W'(nx);
    end

endmodule

// File: rtl/filter_window_sequencer.sv
// Walks a frame in raster order, presents each 3x3 window to the filter and writes the result back.
// Define SEQ_WINDOW_REUSE_EN to slide the window and fetch only the new right column when x > 0.
module filter_window_sequencer
    import filter_pkg::*;
#(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int ADDR_W     = 15,
    parameter int FILTER_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [SLOT_W-1:0] src_rdata,
    output logic [WIN_W-1:0]  win_data,
    input  logic [SLOT_W-1:0] filt_in,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [SLOT_W-1:0] dst_wdata,
    output logic              dst_we
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
`ifdef SEQ_WINDOW_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    seq_state_t        state_reg;
    logic [X_W-1:0]    x_reg;
    logic [Y_W-1:0]    y_reg;
    logic [3:0]        fetch_idx_reg;
    logic              rd_valid_reg;
    logic [3:0]        rd_slot_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              short_fetch;
    logic              last_fetch;
    logic              last_col;
    logic              last_pixel;
    logic              slide_next;
    logic              load_fire;
    logic [3:0]        issue_slot;

    logic [SLOT_W-1:0] new_win [NUM_SLOTS];
    logic [FILTER_LAT-1:0] vld_pipe;
    logic [ADDR_W-1:0] addr_pipe [FILTER_LAT];

    always_comb begin
        short_fetch = REUSE && (x_reg != '0);
        last_fetch  = short_fetch ? (fetch_idx_reg == 4'd2) : (fetch_idx_reg == 4'd8);
        issue_slot  = SLOT_CENTRE;
        if (state_reg == ST_FETCH)
            issue_slot = short_fetch ? reuse_slot(fetch_idx_reg) : fetch_idx_reg;
        last_col    = (x_reg == X_W'(IMG_W - 1));
        last_pixel  = last_col && (y_reg == Y_W'(IMG_H - 1));
        slide_next  = REUSE && !last_col;
        load_fire   = (state_reg == ST_LOAD);
    end

    // Outside FETCH the generator points at the centre pixel, which is the destination address at LOAD.
    window_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_addr_gen (
        .x    (x_reg),
        .y    (y_reg),
        .slot (issue_slot),
        .addr (src_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            fetch_idx_reg <= '0;
            rd_valid_reg  <= 1'b0;
            rd_slot_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            rd_valid_reg <= (state_reg == ST_FETCH);
            rd_slot_reg  <= issue_slot;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg     <= ST_FETCH;
                        x_reg         <= '0;
                        y_reg         <= '0;
                        fetch_idx_reg <= '0;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (last_fetch) begin
                        state_reg     <= ST_LOAD;
                        fetch_idx_reg <= '0;
                    end else begin
                        fetch_idx_reg <= fetch_idx_reg + 4'd1;
                    end
                end
                ST_LOAD: begin
                    if (last_pixel) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        state_reg <= ST_FETCH;
                        if (last_col) begin
                            x_reg <= '0;
                            y_reg <= y_reg + 1'b1;
                        end else begin
                            x_reg <= x_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Only the final window is in flight here, so its write ends the frame.
                    if (dst_we) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-slot staging register filled by returning reads, and the window register shown to the filter.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        localparam logic [3:0] SLOT = 4'(gi);
        localparam logic [3:0] SRC  = shift_src(SLOT);

        logic [SLOT_W-1:0] stage_reg;
        logic [SLOT_W-1:0] win_reg;
        logic              hit;

        assign hit         = rd_valid_reg && (rd_slot_reg == SLOT);
        assign new_win[gi] = hit ? src_rdata : stage_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_reg <= '0;
                win_reg   <= '0;
            end else if (load_fire) begin
                win_reg   <= new_win[gi];
                stage_reg <= slide_next ? new_win[SRC] : new_win[gi];
            end else if (hit) begin
                stage_reg <= src_rdata;
            end
        end

        assign win_data[WIN_W-1-gi*SLOT_W -: SLOT_W] = win_reg;
    end

    // Write token and destination address travel together through a FILTER_LAT-deep pipe.
    for (genvar gi = 0; gi < FILTER_LAT; gi++) begin : g_wr_pipe
        logic              vld_reg;
        logic [ADDR_W-1:0] addr_reg;

        if (gi == 0) begin : g_head
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_reg  <= 1'b0;
                    addr_reg <= '0;
                end else begin
                    vld_reg <= load_fire;
                    if (load_fire)
                        addr_reg <= src_addr;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_reg  <= 1'b0;
                    addr_reg <= '0;
                end else begin
                    vld_reg  <= vld_pipe[gi-1];
                    addr_reg <= addr_pipe[gi-1];
                end
            end
        end

        assign vld_pipe[gi]  = vld_reg;
        assign addr_pipe[gi] = addr_reg;
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign dst_we    = vld_pipe[FILTER_LAT-1];
    assign dst_addr  = addr_pipe[FILTER_LAT-1];
    assign dst_wdata = dst_we ? filt_in : '0;

endmodule
